// File: rtl/mul_share_sched.sv
// Arbiter and sequencer sharing one combinational 8-bit multiplier between two requesters.
// Optional grant statistics counters are enabled by defining MUL_SHARE_SCHED_STATS_EN.
module mul_share_sched #(
  parameter int SETTLE_CYCLES = 1,
  parameter int PRIO_MODE     = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0_valid,
  output logic       req0_ready,
  input  logic [7:0] req0_a,
  input  logic [7:0] req0_b,
  output logic       rsp0_valid,
  input  logic       rsp0_ready,
  output logic [7:0] rsp0_data,
  input  logic       req1_valid,
  output logic       req1_ready,
  input  logic [7:0] req1_a,
  input  logic [7:0] req1_b,
  output logic       rsp1_valid,
  input  logic       rsp1_ready,
  output logic [7:0] rsp1_data,
  output logic [7:0] mul_a,
  output logic [7:0] mul_b,
  input  logic [7:0] mul_out,
`ifdef MUL_SHARE_SCHED_STATS_EN
  output logic [15:0] grant_cnt0,
  output logic [15:0] grant_cnt1,
`endif
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETTLE  = 2'd1,
    RESPOND = 2'd2
  } state_t;

  // Out-of-range settle values are clamped so the counter always terminates.
  localparam logic [3:0] SETTLE_LOAD =
    (SETTLE_CYCLES < 1)  ? 4'd1  :
    (SETTLE_CYCLES > 15) ? 4'd15 : 4'(SETTLE_CYCLES);

  state_t     state;
  logic [3:0] settle_cnt;
  logic       owner;
  logic       last_grant;
  logic       grant0;
  logic       grant1;
  logic       owner_taken;

  // NOTE: every output of this always_comb gets a default first, so no latch is inferred.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (state == IDLE && !rst) begin
      if (PRIO_MODE != 0) begin
        grant0 = req0_valid;
        grant1 = req1_valid && !req0_valid;
      end else if (req0_valid && req1_valid) begin
        // Contention goes to whoever was not granted last.
        grant0 = last_grant;
        grant1 = !last_grant;
      end else begin
        grant0 = req0_valid;
        grant1 = req1_valid;
      end
    end
  end

  assign req0_ready  = grant0;
  assign req1_ready  = grant1;
  assign owner_taken = owner ? rsp1_ready : rsp0_ready;

  // The owner's rspN_data register doubles as the result register; the other port holds.
  // NOTE: all state here uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      settle_cnt <= 4'd0;
      owner      <= 1'b0;
      last_grant <= 1'b1;
      mul_a      <= 8'd0;
      mul_b      <= 8'd0;
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
      rsp0_data  <= 8'd0;
      rsp1_data  <= 8'd0;
      busy       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant0 || grant1) begin
            mul_a      <= grant1 ? req1_a : req0_a;
            mul_b      <= grant1 ? req1_b : req0_b;
            owner      <= grant1;
            last_grant <= grant1;
            settle_cnt <= SETTLE_LOAD;
            state      <= SETTLE;
            busy       <= 1'b1;
          end
        end
        SETTLE: begin
          settle_cnt <= settle_cnt - 4'd1;
          if (settle_cnt == 4'd1) begin
            state <= RESPOND;
            if (owner) begin
              rsp1_valid <= 1'b1;
              rsp1_data  <= mul_out;
            end else begin
              rsp0_valid <= 1'b1;
              rsp0_data  <= mul_out;
            end
          end
        end
        RESPOND: begin
          if (owner_taken) begin
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
            state      <= IDLE;
            busy       <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef MUL_SHARE_SCHED_STATS_EN
  // Saturating per-requester handshake counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      grant_cnt0 <= 16'd0;
      grant_cnt1 <= 16'd0;
    end else begin
      if (grant0 && grant_cnt0 != 16'hFFFF) grant_cnt0 <= grant_cnt0 + 16'd1;
      if (grant1 && grant_cnt1 != 16'hFFFF) grant_cnt1 <= grant_cnt1 + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mul_share_sched.sv
// Directed self-checking bench: dut 0 uses defaults, dut 1 uses SETTLE_CYCLES=4 and fixed priority.
module tb_mul_share_sched;

  logic       clk;
  logic [1:0] rst;
  logic [1:0] req_valid [2];
  logic [1:0] req_ready [2];
  logic [7:0] req_a     [2][2];
  logic [7:0] req_b     [2][2];
  logic [1:0] rsp_valid [2];
  logic [1:0] rsp_ready [2];
  logic [7:0] rsp_data  [2][2];
  logic [7:0] mul_a     [2];
  logic [7:0] mul_b     [2];
  logic [7:0] mul_out   [2];
  logic [1:0] busy;
`ifdef MUL_SHARE_SCHED_STATS_EN
  logic [15:0] grant_cnt0 [2];
  logic [15:0] grant_cnt1 [2];
`endif

  int checks;
  int failures;

  // Stand-in for the shared multiplier: low byte of a*b.
  assign mul_out[0] = mul_a[0] * mul_b[0];
  assign mul_out[1] = mul_a[1] * mul_b[1];

  mul_share_sched #(.SETTLE_CYCLES(1), .PRIO_MODE(0)) dut0 (
    .clk        (clk),
    .rst        (rst[0]),
    .req0_valid (req_valid[0][0]),
    .req0_ready (req_ready[0][0]),
    .req0_a     (req_a[0][0]),
    .req0_b     (req_b[0][0]),
    .rsp0_valid (rsp_valid[0][0]),
    .rsp0_ready (rsp_ready[0][0]),
    .rsp0_data  (rsp_data[0][0]),
    .req1_valid (req_valid[0][1]),
    .req1_ready (req_ready[0][1]),
    .req1_a     (req_a[0][1]),
    .req1_b     (req_b[0][1]),
    .rsp1_valid (rsp_valid[0][1]),
    .rsp1_ready (rsp_ready[0][1]),
    .rsp1_data  (rsp_data[0][1]),
    .mul_a      (mul_a[0]),
    .mul_b      (mul_b[0]),
    .mul_out    (mul_out[0]),
`ifdef MUL_SHARE_SCHED_STATS_EN
    .grant_cnt0 (grant_cnt0[0]),
    .grant_cnt1 (grant_cnt1[0]),
`endif
    .busy       (busy[0])
  );

  mul_share_sched #(.SETTLE_CYCLES(4), .PRIO_MODE(1)) dut1 (
    .clk        (clk),
    .rst        (rst[1]),
    .req0_valid (req_valid[1][0]),
    .req0_ready (req_ready[1][0]),
    .req0_a     (req_a[1][0]),
    .req0_b     (req_b[1][0]),
    .rsp0_valid (rsp_valid[1][0]),
    .rsp0_ready (rsp_ready[1][0]),
    .rsp0_data  (rsp_data[1][0]),
    .req1_valid (req_valid[1][1]),
    .req1_ready (req_ready[1][1]),
    .req1_a     (req_a[1][1]),
    .req1_b     (req_b[1][1]),
    .rsp1_valid (rsp_valid[1][1]),
    .rsp1_ready (rsp_ready[1][1]),
    .rsp1_data  (rsp_data[1][1]),
    .mul_a      (mul_a[1]),
    .mul_b      (mul_b[1]),
    .mul_out    (mul_out[1]),
`ifdef MUL_SHARE_SCHED_STATS_EN
    .grant_cnt0 (grant_cnt0[1]),
    .grant_cnt1 (grant_cnt1[1]),
`endif
    .busy       (busy[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One full transaction on dut d from requester id, response taken immediately.
  task automatic txn(input int d, input int id, input logic [7:0] a, input logic [7:0] b,
                     input logic [7:0] exp, input string tag);
    int n;
    int lat;
    int lat_exp;
    lat_exp = (d == 0) ? 2 : 5;
    req_a[d][id]     = a;
    req_b[d][id]     = b;
    rsp_ready[d][id] = 1'b1;
    req_valid[d][id] = 1'b1;
    #1;
    n = 0;
    while (!req_ready[d][id] && n < 10) begin
      tick;
      n++;
    end
    check({tag, "_ready"}, 16'(req_ready[d][id]), 16'd1);
    check({tag, "_other_ready"}, 16'(req_ready[d][1-id]), 16'd0);
    tick;
    req_valid[d][id] = 1'b0;
    check({tag, "_mul_a"}, 16'(mul_a[d]), 16'(a));
    check({tag, "_mul_b"}, 16'(mul_b[d]), 16'(b));
    check({tag, "_busy"}, 16'(busy[d]), 16'd1);
    lat = 1;
    while (!rsp_valid[d][id] && lat < 20) begin
      tick;
      lat++;
    end
    check({tag, "_latency"}, 16'(lat), 16'(lat_exp));
    check({tag, "_data"}, 16'(rsp_data[d][id]), 16'(exp));
    check({tag, "_other_valid"}, 16'(rsp_valid[d][1-id]), 16'd0);
    tick;
    check({tag, "_taken_valid"}, 16'(rsp_valid[d][id]), 16'd0);
    check({tag, "_idle_busy"}, 16'(busy[d]), 16'd0);
  endtask

  initial begin
    int n;
    int g;
    checks   = 0;
    failures = 0;
    rst      = 2'b11;
    for (int d = 0; d < 2; d++) begin
      req_valid[d] = 2'b00;
      rsp_ready[d] = 2'b00;
      for (int i = 0; i < 2; i++) begin
        req_a[d][i] = 8'd0;
        req_b[d][i] = 8'd0;
      end
    end
    tick;
    tick;

    check("rst_busy", 16'(busy[0]), 16'd0);
    check("rst_mul_a", 16'(mul_a[0]), 16'd0);
    check("rst_mul_b", 16'(mul_b[0]), 16'd0);
    check("rst_rsp_valid", 16'(rsp_valid[0]), 16'd0);
    check("rst_rsp0_data", 16'(rsp_data[0][0]), 16'd0);
    check("rst_rsp1_data", 16'(rsp_data[0][1]), 16'd0);
    check("rst_ready", 16'(req_ready[0]), 16'd0);
    rst = 2'b00;
    tick;

    // Single request and truncating products.
    txn(0, 0, 8'h07, 8'h06, 8'h2A, "single");
    txn(0, 1, 8'hFF, 8'h02, 8'hFE, "trunc_ff");
    txn(0, 1, 8'h10, 8'h10, 8'h00, "trunc_10");

    // Round-robin contention with both requesters held valid.
    req_a[0][0] = 8'd3; req_b[0][0] = 8'd3;
    req_a[0][1] = 8'd4; req_b[0][1] = 8'd4;
    rsp_ready[0] = 2'b11;
    req_valid[0] = 2'b11;
    #1;
    for (int k = 0; k < 4; k++) begin
      g = k % 2;
      n = 0;
      while (req_ready[0] == 2'b00 && n < 10) begin
        tick;
        n++;
      end
      check("rr_grant", 16'(req_ready[0]), (g == 1) ? 16'd2 : 16'd1);
      tick;
      check("rr_settle_ready", 16'(req_ready[0]), 16'd0);
      tick;
      check("rr_rsp_valid", 16'(rsp_valid[0]), (g == 1) ? 16'd2 : 16'd1);
      check("rr_rsp_data", 16'(rsp_data[0][g]), (g == 1) ? 16'h10 : 16'h09);
      tick;
    end
    req_valid[0] = 2'b00;

    // Backpressure on requester 0 while requester 1 waits.
    req_a[0][0] = 8'd5; req_b[0][0] = 8'd5;
    req_a[0][1] = 8'd2; req_b[0][1] = 8'd3;
    rsp_ready[0] = 2'b10;
    req_valid[0] = 2'b11;
    #1;
    check("bp_grant", 16'(req_ready[0]), 16'd1);
    tick;
    req_valid[0][0] = 1'b0;
    tick;
    check("bp_first_valid", 16'(rsp_valid[0][0]), 16'd1);
    check("bp_first_data", 16'(rsp_data[0][0]), 16'h19);
    for (int k = 0; k < 5; k++) begin
      tick;
      check("bp_hold_valid", 16'(rsp_valid[0][0]), 16'd1);
      check("bp_hold_data", 16'(rsp_data[0][0]), 16'h19);
      check("bp_req1_ready", 16'(req_ready[0][1]), 16'd0);
      check("bp_busy", 16'(busy[0]), 16'd1);
    end
    rsp_ready[0][0] = 1'b1;
    tick;
    check("bp_idle_busy", 16'(busy[0]), 16'd0);
    check("bp_idle_valid", 16'(rsp_valid[0][0]), 16'd0);
    check("bp_req1_granted", 16'(req_ready[0][1]), 16'd1);
    tick;
    req_valid[0][1] = 1'b0;
    check("bp_req1_mul_a", 16'(mul_a[0]), 16'd2);
    check("bp_req1_mul_b", 16'(mul_b[0]), 16'd3);
    tick;
    check("bp_req1_data", 16'(rsp_data[0][1]), 16'h06);
    check("bp_req1_valid", 16'(rsp_valid[0][1]), 16'd1);
    tick;

    // A request withdrawn while busy is never captured.
    req_a[0][0] = 8'd2; req_b[0][0] = 8'd2;
    req_valid[0][0] = 1'b1;
    #1;
    tick;
    req_valid[0][0] = 1'b0;
    req_a[0][1] = 8'h99; req_b[0][1] = 8'h99;
    req_valid[0][1] = 1'b1;
    tick;
    check("drop_ready", 16'(req_ready[0][1]), 16'd0);
    check("drop_rsp0_data", 16'(rsp_data[0][0]), 16'h04);
    req_valid[0][1] = 1'b0;
    tick;
    tick;
    check("drop_busy", 16'(busy[0]), 16'd0);
    check("drop_mul_a", 16'(mul_a[0]), 16'd2);

    // Reset during SETTLE aborts the transaction and restores last_grant.
    req_a[0][0] = 8'd9; req_b[0][0] = 8'd9;
    req_valid[0][0] = 1'b1;
    #1;
    tick;
    req_valid[0][0] = 1'b0;
`ifdef MUL_SHARE_SCHED_STATS_EN
    check("stats_cnt0", grant_cnt0[0], 16'd6);
    check("stats_cnt1", grant_cnt1[0], 16'd5);
`endif
    rst[0] = 1'b1;
    tick;
    check("abort_mul_a", 16'(mul_a[0]), 16'd0);
    check("abort_mul_b", 16'(mul_b[0]), 16'd0);
    check("abort_busy", 16'(busy[0]), 16'd0);
    check("abort_rsp_valid", 16'(rsp_valid[0]), 16'd0);
    check("abort_rsp0_data", 16'(rsp_data[0][0]), 16'd0);
    check("abort_rsp1_data", 16'(rsp_data[0][1]), 16'd0);
`ifdef MUL_SHARE_SCHED_STATS_EN
    check("abort_cnt0", grant_cnt0[0], 16'd0);
    check("abort_cnt1", grant_cnt1[0], 16'd0);
`endif
    rst[0] = 1'b0;
    n = 0;
    for (int k = 0; k < 3; k++) begin
      tick;
      if (rsp_valid[0] != 2'b00) n++;
    end
    check("abort_no_response", 16'(n), 16'd0);
    req_a[0][0] = 8'd1; req_b[0][0] = 8'd1;
    req_a[0][1] = 8'd1; req_b[0][1] = 8'd1;
    req_valid[0] = 2'b11;
    #1;
    check("abort_first_grant", 16'(req_ready[0]), 16'd1);
    req_valid[0] = 2'b00;

    // Longer settle time and fixed priority on dut 1.
    txn(1, 0, 8'h0C, 8'h0B, 8'h84, "settle4");
    req_a[1][0] = 8'd1; req_b[1][0] = 8'd1;
    req_a[1][1] = 8'd1; req_b[1][1] = 8'd1;
    rsp_ready[1] = 2'b11;
    req_valid[1] = 2'b11;
    #1;
    for (int k = 0; k < 2; k++) begin
      check("prio_grant", 16'(req_ready[1]), 16'd1);
      tick;
      repeat (5) tick;
    end
    req_valid[1] = 2'b00;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
